// File: rtl/sd_bd_fetch.sv
// Reads one buffer descriptor from the BD store, dispatches it to the SD engine and retires it.
// Build option: define SD_BD_FETCH_TIMEOUT_EN to add a BUSY watchdog of TIMEOUT cycles.
//
// state      | meaning
// S_IDLE     | waiting for a pending BD (free_bd < BD_DEPTH)
// S_READ     | one re_s pulse per cycle, WORDS_PER_BD pulses
// S_DRAIN    | waiting for the last word out of the read-latency pipe
// S_DISPATCH | cmd_valid held until the engine accepts
// S_BUSY     | waiting for xfer_done (or watchdog)
// S_ACK      | a_cmp pulse, counter bumps
// S_GAP      | quiet cycle so the store can update free_bd
module sd_bd_fetch #(
  parameter int MEM_W        = 16,
  parameter int WORDS_PER_BD = 4,
  parameter int BD_DEPTH     = 8,
  parameter int CNT_W        = 4,
  parameter int RD_LAT       = 1,
  parameter int TIMEOUT      = 1023
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CNT_W-1:0]                  free_bd,
  input  logic [MEM_W-1:0]                  dat_out_s,
  output logic                              re_s,
  output logic                              a_cmp,
  output logic                              cmd_valid,
  input  logic                              cmd_ready,
  output logic [MEM_W*WORDS_PER_BD/2-1:0]   cmd_addr,
  output logic [MEM_W*WORDS_PER_BD/2-1:0]   cmd_arg,
  input  logic                              xfer_done,
  input  logic                              xfer_err,
  output logic                              cmp_err,
  output logic                              busy,
  output logic [15:0]                       bd_done_cnt
);
  localparam int BD_W = MEM_W * WORDS_PER_BD;
  localparam int HALF = BD_W / 2;
  localparam int WC_W = (WORDS_PER_BD > 2) ? $clog2(WORDS_PER_BD) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_BD - 1);

  if (RD_LAT < 1 || RD_LAT > 3 || WORDS_PER_BD < 2 || (WORDS_PER_BD % 2) != 0 || TIMEOUT < 1)
  begin : g_bad_params
    $error("sd_bd_fetch: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_DISPATCH, S_BUSY, S_ACK, S_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [WC_W-1:0]        rd_cnt_q, rd_cnt_d, cap_cnt_q, cap_cnt_d;
  logic [RD_LAT-1:0]      pipe_q, pipe_d;
  logic [BD_W-MEM_W-1:0]  bd_q, bd_d;
  logic                   re_s_q, re_s_d, a_cmp_q, a_cmp_d, cmd_valid_q, cmd_valid_d;
  logic                   cmp_err_q, cmp_err_d, busy_q, busy_d;
  logic [HALF-1:0]        cmd_addr_q, cmd_addr_d, cmd_arg_q, cmd_arg_d;
  logic [15:0]            done_cnt_q, done_cnt_d;

  logic            cap, pending;
  logic [BD_W-1:0] bd_sh;

`ifdef SD_BD_FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign cap     = pipe_q[RD_LAT-1];
  assign bd_sh   = {bd_q, dat_out_s};
  // Out-of-range counts from the store read as "empty".
  assign pending = free_bd < CNT_W'(BD_DEPTH);

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    pipe_d      = pipe_q << 1;
    pipe_d[0]   = re_s_q;
    bd_d        = bd_q;
    re_s_d      = 1'b0;
    a_cmp_d     = 1'b0;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_arg_d   = cmd_arg_q;
    cmp_err_d   = cmp_err_q;
    done_cnt_d  = done_cnt_q;
`ifdef SD_BD_FETCH_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    if (cap) begin
      bd_d      = bd_sh[BD_W-MEM_W-1:0];
      cap_cnt_d = cap_cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (pending) begin
          state_d  = S_READ;
          re_s_d   = 1'b1;
          rd_cnt_d = '0;
        end
      end
      S_READ: begin
        if (rd_cnt_q == LAST_WORD) begin
          state_d  = S_DRAIN;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          re_s_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cap && cap_cnt_q == LAST_WORD) begin
          state_d     = S_DISPATCH;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = bd_sh[BD_W-1 -: HALF];
          cmd_arg_d   = bd_sh[HALF-1:0];
          cap_cnt_d   = '0;
        end
      end
      S_DISPATCH: begin
        if (cmd_ready) begin
          state_d     = S_BUSY;
          cmd_valid_d = 1'b0;
`ifdef SD_BD_FETCH_TIMEOUT_EN
          to_cnt_d    = TO_W'(TIMEOUT - 1);
`endif
        end
      end
      S_BUSY: begin
        if (xfer_done) begin
          state_d    = S_ACK;
          a_cmp_d    = 1'b1;
          cmp_err_d  = xfer_err;
          done_cnt_d = done_cnt_q + 16'd1;
        end
`ifdef SD_BD_FETCH_TIMEOUT_EN
        else if (to_cnt_q == '0) begin
          state_d    = S_ACK;
          a_cmp_d    = 1'b1;
          cmp_err_d  = 1'b1;
          done_cnt_d = done_cnt_q + 16'd1;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
        end
`endif
      end
      S_ACK: state_d = S_GAP;
      S_GAP: begin
        state_d   = S_IDLE;
        cmp_err_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      cap_cnt_q   <= '0;
      pipe_q      <= '0;
      bd_q        <= '0;
      re_s_q      <= 1'b0;
      a_cmp_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_arg_q   <= '0;
      cmp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_cnt_q  <= '0;
`ifdef SD_BD_FETCH_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      pipe_q      <= pipe_d;
      bd_q        <= bd_d;
      re_s_q      <= re_s_d;
      a_cmp_q     <= a_cmp_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_arg_q   <= cmd_arg_d;
      cmp_err_q   <= cmp_err_d;
      busy_q      <= busy_d;
      done_cnt_q  <= done_cnt_d;
`ifdef SD_BD_FETCH_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign re_s        = re_s_q;
  assign a_cmp       = a_cmp_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_arg     = cmd_arg_q;
  assign cmp_err     = cmp_err_q;
  assign busy        = busy_q;
  assign bd_done_cnt = done_cnt_q;

endmodule

// File: doc/sd_bd_fetch.md
Name: sd_bd_fetch

Overview:
- Consumer side of the SD buffer-descriptor (BD) store.
- Detects pending BDs from the store's free-slot count.
- Reads one BD word by word through re_s/dat_out_s and assembles it into an address/argument command.
- Hands the command to the SD data/command engine, waits for that engine to finish, then retires the BD with a one-cycle a_cmp pulse.

Parameters:
- MEM_W, 16, width of one BD store word (matches RAM_MEM_WIDTH).
- WORDS_PER_BD, 4, store words per BD; must be even, min 2.
- BD_DEPTH, 8, BD store capacity; free_bd == BD_DEPTH means empty.
- CNT_W, 4, width of free_bd; must hold BD_DEPTH.
- RD_LAT, 1, cycles from re_s sampled high to dat_out_s valid; min 1, max 3.
- TIMEOUT, 1023, BUSY watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- free_bd  in  CNT_W  free BD slots reported by the store.
- dat_out_s  in  MEM_W  store read data, valid RD_LAT cycles after re_s.
- re_s  out  1  store read strobe, one pulse per word.
- a_cmp  out  1  one-cycle BD retire pulse to the store.
- cmd_valid  out  1  assembled command valid.
- cmd_ready  in  1  engine accepts command.
- cmd_addr  out  MEM_W*WORDS_PER_BD/2  first half of BD (buffer address).
- cmd_arg  out  MEM_W*WORDS_PER_BD/2  second half of BD (card argument).
- xfer_done  in  1  engine finished current BD (pulse).
- xfer_err  in  1  error qualifier, sampled with xfer_done.
- cmp_err  out  1  error status, valid in the a_cmp cycle.
- busy  out  1  high in every state except IDLE.
- bd_done_cnt  out  16  retired-BD counter, wraps at 0xFFFF -> 0.

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE.
  - re_s, a_cmp, cmd_valid, cmp_err, busy = 0; cmd_addr, cmd_arg = 0; bd_done_cnt = 0.
  - Word counter and latency pipe are cleared; any partially read BD is discarded.
  - Reset has priority over everything, including mid-READ and mid-BUSY.
- IDLE:
  - If free_bd != BD_DEPTH, go to READ next cycle.
  - free_bd > BD_DEPTH is treated as empty.
- READ:
  - re_s is high exactly one cycle per word, on consecutive cycles, WORDS_PER_BD pulses total, then go to DRAIN.
  - Data is captured via a RD_LAT-deep valid pipe.
  - The k-th captured word (k = 0 first) fills bits [BD_W-1-k*MEM_W -: MEM_W], where BD_W = MEM_W*WORDS_PER_BD. First word read is the most significant.
  - cmd_addr takes the upper BD_W/2 bits; cmd_arg takes the lower BD_W/2 bits.
- DRAIN:
  - Wait until the last word is captured.
  - Go to DISPATCH; cmd_valid rises in the first DISPATCH cycle.
  - With RD_LAT=1: re_s pulses in cycles T..T+3, last capture at T+4, cmd_valid high at T+5.
- DISPATCH:
  - cmd_valid is held high; cmd_addr/cmd_arg are stable until cmd_valid && cmd_ready.
  - On handshake, cmd_valid drops the next cycle; go to BUSY.
- BUSY:
  - Wait for xfer_done; xfer_done is ignored in all other states.
  - On xfer_done, latch cmp_err = xfer_err and go to ACK.
- ACK:
  - a_cmp = 1 for exactly one cycle; bd_done_cnt increments in the same cycle.
  - Go to GAP.
- GAP:
  - One cycle with no strobes, so the store can update free_bd; then go to IDLE.
  - cmp_err clears on leaving GAP.
- Back-to-back: with BDs still pending, IDLE re-enters READ one cycle after GAP. Minimum BD turnaround is WORDS_PER_BD+RD_LAT+5 cycles plus engine time.
- re_s and a_cmp are never high in the same cycle.
- At most one BD is in flight.

Optional Feature:
- Macro SD_BD_FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs in BUSY, cleared on BUSY entry.
  - If it reaches TIMEOUT with no xfer_done, go to ACK with cmp_err = 1.
  - xfer_done arriving in the same cycle as the timeout wins, with cmp_err = xfer_err.
  - A late xfer_done after the timeout is ignored.
- Undefined: no counter; BUSY waits indefinitely.

Test Plan:
- Empty store: free_bd=8 held 50 cycles after reset -> re_s, a_cmp, cmd_valid stay 0; busy=0.
- Single BD (RD_LAT=1): free_bd=7; words 0x1234, 0x5678, 0x9ABC, 0xDEF0 -> exactly 4 one-cycle re_s pulses; cmd_addr=0x12345678, cmd_arg=0x9ABCDEF0; cmd_valid held through 3 cycles of cmd_ready=0.
- Retire: after the handshake, xfer_done=1 with xfer_err=1 -> one a_cmp pulse with cmp_err=1; bd_done_cnt 0 -> 1; one idle GAP cycle follows.
- Back-to-back: free_bd stays below 8 for 3 BDs (engine returns xfer_done 2 cycles after handshake) -> 3 a_cmp pulses; bd_done_cnt=3; re_s and a_cmp never overlap.
- Reset mid-operation: rst=0 after the 2nd re_s pulse -> next cycle all outputs are 0 and state is IDLE; on release with a BD pending, a fresh 4-word read starts from word 0.
- Timeout (macro defined, TIMEOUT=20): no xfer_done -> a_cmp exactly 20 cycles after BUSY entry, with cmp_err=1; a later xfer_done causes no extra a_cmp.
